// File: rtl/spi_frame_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Brief    : Shared frame geometry, field positions and FSM state encoding.
//  Revision : 1.0
// ============================================================================
package spi_pkg;

   localparam int DEF_FRAME_BITS = 10;
   localparam int DEF_TX_BITS    = 8;

   // Operand frame layout {a[3:0], b[3:0], Sel[1:0]}
   localparam int A_MSB   = 9;
   localparam int A_LSB   = 6;
   localparam int B_MSB   = 5;
   localparam int B_LSB   = 2;
   localparam int SEL_MSB = 1;
   localparam int SEL_LSB = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_frame_sync_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge
//  Brief    : Multi-flop synchroniser with registered-history edge pulses.
//  Revision : 1.0
// ============================================================================
module sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_q    = r_sync[SYNC_STAGES-1];
   assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_sync
//  Brief    : clk-domain SPI mode-0 slave: captures one operand frame per SS
//             window and returns a status word on MISO.
//  Revision : 1.0
// ============================================================================
module spi_frame_sync
   import spi_pkg::*;
#(
   parameter int FRAME_BITS  = DEF_FRAME_BITS,
   parameter int TX_BITS     = DEF_TX_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  SCLK,
   input  logic                  MOSI,
   input  logic                  SS,
   input  logic [TX_BITS-1:0]    tx_data,
   output logic                  MISO,
   output logic [FRAME_BITS-1:0] frame_out,
   output logic                  frame_valid,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int                 c_CNT_W    = $clog2(FRAME_BITS + 2);
   localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FRAME_BITS);
   localparam logic [c_CNT_W-1:0] c_CNT_OVF  = c_CNT_W'(FRAME_BITS + 1);

   logic w_sclk_q, w_sclk_rise, w_sclk_fall;
   logic w_mosi_q, w_mosi_rise, w_mosi_fall;
   logic w_ss_q,   w_ss_rise,   w_ss_fall;
   logic w_unused;

   state_t                  r_state, w_state_nxt;
   logic                    w_load;
   logic [FRAME_BITS-1:0]   r_rx;
   logic [TX_BITS-1:0]      r_tx;
   logic [c_CNT_W-1:0]      r_cnt;
   logic [FRAME_BITS-1:0]   r_frame;
   logic                    r_valid;
   logic                    r_err;
   logic                    r_hold;
   logic [SYNC_STAGES:0]    r_settle;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk    (clk),
      .rst    (rst),
      .i_d    (SCLK),
      .o_q    (w_sclk_q),
      .o_rise (w_sclk_rise),
      .o_fall (w_sclk_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk    (clk),
      .rst    (rst),
      .i_d    (MOSI),
      .o_q    (w_mosi_q),
      .o_rise (w_mosi_rise),
      .o_fall (w_mosi_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .clk    (clk),
      .rst    (rst),
      .i_d    (SS),
      .o_q    (w_ss_q),
      .o_rise (w_ss_rise),
      .o_fall (w_ss_fall)
   );

   // Frame entry is level-based, so the SS fall pulse is not needed.
   assign w_unused = ^{w_sclk_q, w_mosi_rise, w_mosi_fall, w_ss_fall};

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_ss_q && !r_hold) begin
               w_state_nxt = SHIFT;
               w_load      = 1'b1;
            end
         end
         SHIFT: begin
            if (w_ss_rise) w_state_nxt = DONE;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // r_hold blocks frame entry after reset until SS is seen high once the
   // preset synchroniser contents have flushed, so a partial frame that was
   // in flight across reset is never captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx     <= '0;
         r_tx     <= '0;
         r_cnt    <= c_CNT_ZERO;
         r_frame  <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_hold   <= 1'b1;
         r_settle <= '0;
      end else begin
         r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
         r_valid  <= 1'b0;
         r_err    <= 1'b0;

         if (r_settle[SYNC_STAGES] && w_ss_q) r_hold <= 1'b0;

         if (w_load) begin
            r_tx  <= tx_data;
            r_rx  <= '0;
            r_cnt <= c_CNT_ZERO;
         end else if (r_state == SHIFT) begin
            if (w_sclk_rise) begin
               r_rx <= {r_rx[FRAME_BITS-2:0], w_mosi_q};
               if (r_cnt != c_CNT_OVF) r_cnt <= r_cnt + c_CNT_ONE;
            end
            // Mode 0: the first falling edge after a rising edge advances MISO.
            if (w_sclk_fall && (r_cnt != c_CNT_ZERO)) begin
               r_tx <= {r_tx[TX_BITS-2:0], 1'b0};
            end
         end

         if (r_state == DONE) begin
            if (r_cnt == c_CNT_FULL) begin
               r_frame <= r_rx;
               r_valid <= 1'b1;
            end else begin
               r_err   <= 1'b1;
            end
         end
      end
   end

   assign MISO        = (r_state == SHIFT) ? r_tx[TX_BITS-1] : 1'b0;
   assign busy        = (r_state == SHIFT);
   assign frame_out   = r_frame;
   assign frame_valid = r_valid;
   assign frame_err   = r_err;

endmodule
`default_nettype wire

// File: doc/spi_frame_sync.md
Name: spi_frame_sync

Overview:
- Clock-domain SPI frame receiver that replaces the free-running SCLK-clocked slave in front of the ALU.
- Synchronises SCLK/MOSI/SS into clk, deserialises one 10-bit operand frame {a[3:0], b[3:0], Sel[1:0]} and presents it as a stable registered word with a one-cycle valid strobe.
- Simultaneously shifts a status byte (ALU Result and flags) back on MISO, so the master reads the previous operation's result during the next frame.

Parameters:
- FRAME_BITS, 10, number of MOSI bits per valid frame.
- TX_BITS, 8, width of the status word returned on MISO.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock; SCLK must run at ≤ clk/8.
- rst  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock, asynchronous to clk; mode 0.
- MOSI  in  1  SPI data in, MSB first.
- SS  in  1  slave select, active low, asynchronous.
- tx_data  in  TX_BITS  status word {Result[3:0], N, Z, C, V}; sampled at frame start.
- MISO  out  1  SPI data out, MSB first.
- frame_out  out  FRAME_BITS  last good frame; bits[9:6]=a, [5:2]=b, [1:0]=Sel.
- frame_valid  out  1  one-cycle pulse when frame_out updates.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (rst=1 at a clk edge):
  - frame_out=0, frame_valid=0, frame_err=0, busy=0, MISO=0.
  - Synchronisers are preset to the idle values (SCLK=0, SS=1, MOSI=0).
  - Bit counter=0, state=IDLE.
- Synchronisation: SCLK, MOSI and SS each pass through SYNC_STAGES flops. Edge detection compares the last synchronised stage with one further registered copy:
  - sclk_rise, sclk_fall, ss_fall, ss_rise are each one-cycle pulses.
- FSM with states IDLE, SHIFT, DONE.
- IDLE:
  - MISO=0, busy=0.
  - On ss_fall: load tx_data into the TX shift register, clear the RX shift register and bit counter, then go to SHIFT.
  - MISO presents tx_data[TX_BITS-1] from the next cycle.
- SHIFT:
  - busy=1.
  - On sclk_rise: shift synchronised MOSI into RX LSB (shift left) and increment the bit counter. The counter saturates at FRAME_BITS+1, which marks overflow.
  - On sclk_fall, and only if at least one rising edge has occurred in this frame: shift TX left, filling with 0. MISO always equals TX MSB.
  - After TX_BITS shifts MISO outputs 0.
  - On ss_rise: go to DONE.
- DONE (exactly one cycle):
  - If count==FRAME_BITS: frame_out<=RX, frame_valid=1.
  - Otherwise (short or overflowed frame): frame_err=1, frame_out holds.
  - Next state is IDLE, and busy drops.
- Latency: frame_valid/frame_err is asserted SYNC_STAGES+2 clk cycles after the SS pin rises (for SYNC_STAGES=2, 4 cycles).
- frame_out changes only in the DONE cycle and is otherwise held. Downstream ALU/PWM/BCD see glitch-free operands.
- Simultaneous events:
  - ss_rise and sclk_rise in the same cycle: the sclk_rise is processed first (the bit is counted), then DONE.
  - ss_fall while in DONE: ignored.
  - ss_fall detected in IDLE on the following cycle is processed normally, because the edge pulse is re-derived from a level that is still low. Implementation: IDLE enters SHIFT when synchronised SS is low and a frame-ended flag is clear, so back-to-back frames are not lost.
- SCLK edges while SS is high are ignored.
- Reset mid-frame: the frame is aborted with no valid or err pulse. The FSM then waits for SS to go high before accepting a new ss_fall, so a partial frame is never captured.

Decomposition:
- Shared package spi_pkg:
  - FRAME_BITS and TX_BITS defaults.
  - State enum typedef {IDLE, SHIFT, DONE}.
  - Field-position constants A_MSB=9, A_LSB=6, B_MSB=5, B_LSB=2, SEL_MSB=1, SEL_LSB=0.
- One sub-module, sync_edge: a SYNC_STAGES-deep synchroniser plus rise/fall pulse outputs with a reset value parameter. It is instantiated three times.

Test Plan:
- Good frame: reset, tx_data=8'hA5, SS low, clock MOSI 0110010110 (MSB first), SS high → frame_valid pulses once; frame_out=10'b0110010110 (a=6, b=5, Sel=2); MISO over the frame reads 1,0,1,0,0,1,0,1,0,0.
- Short frame: 7 bits then SS high → frame_err one pulse, frame_valid=0, frame_out keeps the previous value 10'h196.
- Overflow: 12 bits sent → frame_err=1, frame_out unchanged.
- Back-to-back: two good frames 10'h196 then 10'h0F3 with SS high for only 4 clk cycles between them → two frame_valid pulses; final frame_out=10'h0F3; the second frame's MISO reflects tx_data sampled at its own SS fall.
- Reset mid-frame: rst after 5 bits, SS stays low, then 10 more bits and SS high → no frame_valid/err pulse; frame_out=0.
- Latency/noise: toggle SCLK with SS high, 6 edges → no busy, no pulses; measure SS pin rise to frame_valid = 4 clk cycles.
